// File: rtl/if_pkg.sv
// Shared types for the IF-stage PC register.
// Pending-redirect states, redirect sources and alignment helpers.
package if_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pend_state_e;

  typedef enum logic [2:0] {
    SRC_TRAP = 3'd0,
    SRC_JALR = 3'd1,
    SRC_BR   = 3'd2,
    SRC_JAL  = 3'd3,
    SRC_SEQ  = 3'd4
  } redirect_src_e;

  localparam int DEF_ILEN_BYTES = 4;
  localparam int ALIGN_MASK     = DEF_ILEN_BYTES - 1;

endpackage

// File: rtl/pc_fetch_reg_if.sv
// Control/redirect bundle between hazard/EX logic and the PC register.
// master = redirect/stall producer, slave = PC register.
interface pc_fetch_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             en;
  logic             clear;
  logic             trap_req;
  logic [XLEN-1:0]  trap_target;
  logic             jalr_taken;
  logic [XLEN-1:0]  jalr_target;
  logic             br_taken;
  logic [XLEN-1:0]  br_target;
  logic             jal_taken;
  logic [XLEN-1:0]  jal_target;
  logic [XLEN-1:0]  PCF;
  logic             pcf_valid;
  logic             misalign_fault;
  logic [XLEN-1:0]  fault_addr;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output en, clear,
    output trap_req, trap_target,
    output jalr_taken, jalr_target,
    output br_taken, br_target,
    output jal_taken, jal_target,
    input  PCF, pcf_valid,
    input  misalign_fault, fault_addr,
    input  redirect_cnt
  );

  modport slave (
    input  en, clear,
    input  trap_req, trap_target,
    input  jalr_taken, jalr_target,
    input  br_taken, br_target,
    input  jal_taken, jal_target,
    output PCF, pcf_valid,
    output misalign_fault, fault_addr,
    output redirect_cnt
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect arbiter: trap > jalr > br > jal.
// Purely combinational; SRC_SEQ means no redirect requested.
module pc_redirect_arb
  import if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_taken,
  input  logic [XLEN-1:0] jal_target,
  output logic            sel_vld,
  output redirect_src_e   sel_src,
  output logic [XLEN-1:0] sel_target
);

  always_comb begin
    sel_vld    = trap_req | jalr_taken
               | br_taken | jal_taken;
    sel_src    = SRC_SEQ;
    sel_target = '0;
    priority case (1'b1)
      trap_req: begin
        sel_src    = SRC_TRAP;
        sel_target = trap_target;
      end
      jalr_taken: begin
        sel_src    = SRC_JALR;
        sel_target = jalr_target;
      end
      br_taken: begin
        sel_src    = SRC_BR;
        sel_target = br_target;
      end
      jal_taken: begin
        sel_src    = SRC_JAL;
        sel_target = jal_target;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_fetch_reg.sv
// IF-stage PC register: prioritised redirects, stall buffering,
// flush-able valid bit, misalignment trap and redirect counter.
module pc_fetch_reg
  import if_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              ILEN_BYTES = 4,
  parameter logic [XLEN-1:0] TRAP_VEC   = '0,
  parameter int              CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_reg_if.slave bus
);

  localparam logic [XLEN-1:0] AMASK =
    XLEN'(ILEN_BYTES - 1);
  localparam logic [XLEN-1:0] STEP =
    XLEN'(ILEN_BYTES);

  logic            sel_vld;
  redirect_src_e   sel_src;
  logic [XLEN-1:0] sel_target;

  pend_state_e      pend_q, pend_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [XLEN-1:0]  pcf_q, pcf_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  faddr_q, faddr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             apply;
  logic [XLEN-1:0]  tgt;

  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .trap_req    (bus.trap_req),
    .trap_target (bus.trap_target),
    .jalr_taken  (bus.jalr_taken),
    .jalr_target (bus.jalr_target),
    .br_taken    (bus.br_taken),
    .br_target   (bus.br_target),
    .jal_taken   (bus.jal_taken),
    .jal_target  (bus.jal_target),
    .sel_vld     (sel_vld),
    .sel_src     (sel_src),
    .sel_target  (sel_target)
  );

  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    pcf_d     = pcf_q;
    valid_d   = valid_q;
    fault_d   = 1'b0;
    faddr_d   = faddr_q;
    cnt_d     = cnt_q;
    // a live redirect always beats a buffered one
    unique case (sel_src)
      SRC_SEQ: begin
        apply = (pend_q == PEND);
        tgt   = pend_pc_q;
      end
      default: begin
        apply = 1'b1;
        tgt   = sel_target;
      end
    endcase
    if (bus.en) begin
      pend_d  = IDLE;
      valid_d = ~bus.clear;
      if (apply) begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
        if ((tgt & AMASK) != '0) begin
          pcf_d   = TRAP_VEC;
          fault_d = 1'b1;
          faddr_d = tgt;
        end else begin
          pcf_d = tgt;
        end
      end else begin
        pcf_d = pcf_q + STEP;
      end
    end else begin
      if (bus.clear)
        valid_d = 1'b0;
      if (sel_vld) begin
        pend_d    = PEND;
        pend_pc_d = sel_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= IDLE;
      pend_pc_q <= '0;
      pcf_q     <= RESET_PC;
      valid_q   <= 1'b1;
      fault_q   <= 1'b0;
      faddr_q   <= '0;
      cnt_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      pcf_q     <= pcf_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      faddr_q   <= faddr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PCF            = pcf_q;
  assign bus.pcf_valid      = valid_q;
  assign bus.misalign_fault = fault_q;
  assign bus.fault_addr     = faddr_q;
  assign bus.redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Bench for pc_fetch_reg: directed scenarios plus randomized
// traffic against a behavioural model; second instance for wrap/saturate.
module tb_pc_fetch_reg;

  localparam logic [31:0] TV = 32'h0000_0080;
  localparam int          IL = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;

  always #5 clk = ~clk;

  pc_fetch_reg_if #(.XLEN(32), .CNT_W(16)) bus ();
  pc_fetch_reg_if #(.XLEN(8),  .CNT_W(2))  sbus ();

  pc_fetch_reg #(
    .XLEN(32), .RESET_PC(32'h0), .ILEN_BYTES(IL),
    .TRAP_VEC(TV), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pc_fetch_reg #(
    .XLEN(8), .RESET_PC(8'hF8), .ILEN_BYTES(4),
    .TRAP_VEC(8'h20), .CNT_W(2)
  ) sdut (
    .clk (clk),
    .rst (rst_s),
    .bus (sbus.slave)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ppc, m_faddr;
  logic        m_v, m_pend, m_flt;
  logic [15:0] m_cnt;

  task automatic idle_in();
    bus.en = 1'b1;       bus.clear = 1'b0;
    bus.trap_req = 1'b0; bus.trap_target = '0;
    bus.jalr_taken = 1'b0; bus.jalr_target = '0;
    bus.br_taken = 1'b0; bus.br_target = '0;
    bus.jal_taken = 1'b0; bus.jal_target = '0;
  endtask

  task automatic model_step();
    logic        hit;
    logic [31:0] t;
    if (rst) begin
      m_pc = 32'h0; m_v = 1'b1; m_pend = 1'b0; m_ppc = '0;
      m_flt = 1'b0; m_faddr = '0; m_cnt = '0;
      return;
    end
    hit = 1'b1;
    t = '0;
    if (bus.trap_req) t = bus.trap_target;
    else if (bus.jalr_taken) t = bus.jalr_target;
    else if (bus.br_taken) t = bus.br_target;
    else if (bus.jal_taken) t = bus.jal_target;
    else hit = 1'b0;
    m_flt = 1'b0;
    if (bus.en) begin
      if (!hit && m_pend) begin
        hit = 1'b1;
        t = m_ppc;
      end
      m_pend = 1'b0;
      if (hit) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (t % IL != 0) begin
          m_pc = TV; m_flt = 1'b1; m_faddr = t;
        end else begin
          m_pc = t;
        end
      end else begin
        m_pc = m_pc + IL;
      end
      m_v = !bus.clear;
    end else begin
      if (bus.clear) m_v = 1'b0;
      if (hit) begin
        m_pend = 1'b1;
        m_ppc = t;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.PCF !== 32'h0 || bus.pcf_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pc got %h/%b want 0/1",
               bus.PCF, bus.pcf_valid);
    end
    checks++;
    if (bus.redirect_cnt !== 16'd0 || bus.misalign_fault !== 1'b0
        || bus.fault_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_misc cnt %0d flt %b fa %h want 0/0/0",
               bus.redirect_cnt, bus.misalign_fault, bus.fault_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.PCF !== 32'(i * 4) || bus.pcf_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_%0d got %h want %h", i, bus.PCF, i * 4);
      end
    end
  endtask

  task automatic test_priority();
    bus.br_taken = 1'b1;  bus.br_target = 32'h100;
    bus.jal_taken = 1'b1; bus.jal_target = 32'h200;
    tick();
    idle_in();
    checks++;
    if (bus.PCF !== 32'h100 || bus.redirect_cnt !== 16'd1) begin
      errors++;
      $display("FAIL br_over_jal got %h cnt %0d want 100 cnt 1",
               bus.PCF, bus.redirect_cnt);
    end
  endtask

  task automatic test_stall_redirect();
    bus.en = 1'b0;
    bus.jalr_taken = 1'b1; bus.jalr_target = 32'h40;
    tick();
    bus.jalr_taken = 1'b0;
    checks++;
    if (bus.PCF !== 32'h100) begin
      errors++;
      $display("FAIL stall_hold1 got %h want 100", bus.PCF);
    end
    tick();
    checks++;
    if (bus.PCF !== 32'h100) begin
      errors++;
      $display("FAIL stall_hold2 got %h want 100", bus.PCF);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.PCF !== 32'h40 || bus.redirect_cnt !== 16'd2) begin
      errors++;
      $display("FAIL pend_apply got %h cnt %0d want 40 cnt 2",
               bus.PCF, bus.redirect_cnt);
    end
    tick();
    checks++;
    if (bus.PCF !== 32'h44) begin
      errors++;
      $display("FAIL pend_after got %h want 44", bus.PCF);
    end
  endtask

  task automatic test_misalign();
    bus.br_taken = 1'b1; bus.br_target = 32'h102;
    tick();
    idle_in();
    checks++;
    if (bus.PCF !== TV || bus.misalign_fault !== 1'b1
        || bus.fault_addr !== 32'h102) begin
      errors++;
      $display("FAIL misalign got pc %h flt %b fa %h want %h/1/102",
               bus.PCF, bus.misalign_fault, bus.fault_addr, TV);
    end
    tick();
    checks++;
    if (bus.misalign_fault !== 1'b0 || bus.fault_addr !== 32'h102
        || bus.PCF !== TV + 4) begin
      errors++;
      $display("FAIL misalign_after flt %b fa %h pc %h want 0/102/%h",
               bus.misalign_fault, bus.fault_addr, bus.PCF, TV + 4);
    end
  endtask

  task automatic test_clear();
    bus.en = 1'b0; bus.clear = 1'b1;
    tick();
    checks++;
    if (bus.pcf_valid !== 1'b0 || bus.PCF !== TV + 4) begin
      errors++;
      $display("FAIL clear_stall v %b pc %h want 0/%h",
               bus.pcf_valid, bus.PCF, TV + 4);
    end
    bus.en = 1'b1; bus.clear = 1'b0;
    tick();
    checks++;
    if (bus.pcf_valid !== 1'b1 || bus.PCF !== TV + 8) begin
      errors++;
      $display("FAIL clear_release v %b pc %h want 1/%h",
               bus.pcf_valid, bus.PCF, TV + 8);
    end
  endtask

  task automatic test_back_to_back();
    bus.en = 1'b0;
    bus.jalr_taken = 1'b1; bus.jalr_target = 32'h300;
    tick();
    idle_in();
    bus.en = 1'b0;
    bus.trap_req = 1'b1; bus.trap_target = 32'h500;
    tick();
    idle_in();
    tick();
    checks++;
    if (bus.PCF !== 32'h500) begin
      errors++;
      $display("FAIL newest_pend got %h want 500", bus.PCF);
    end
    bus.en = 1'b0;
    bus.br_taken = 1'b1; bus.br_target = 32'h600;
    tick();
    idle_in();
    bus.jal_taken = 1'b1; bus.jal_target = 32'h700;
    tick();
    idle_in();
    checks++;
    if (bus.PCF !== 32'h700) begin
      errors++;
      $display("FAIL live_over_pend got %h want 700", bus.PCF);
    end
    tick();
    checks++;
    if (bus.PCF !== 32'h704) begin
      errors++;
      $display("FAIL pend_discard got %h want 704", bus.PCF);
    end
    bus.en = 1'b0;
    bus.jal_taken = 1'b1; bus.jal_target = 32'h900;
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.PCF !== 32'h4 || bus.redirect_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_stall got %h cnt %0d want 4 cnt 0",
               bus.PCF, bus.redirect_cnt);
    end
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) t = t | 32'(1 << $urandom_range(0, 1));
    return t;
  endfunction

  task automatic test_random();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.en = ($urandom_range(0, 9) < 7);
      bus.clear = ($urandom_range(0, 9) == 0);
      bus.trap_req = ($urandom_range(0, 19) == 0);
      bus.trap_target = rnd_tgt();
      bus.jalr_taken = ($urandom_range(0, 9) == 0);
      bus.jalr_target = rnd_tgt();
      bus.br_taken = ($urandom_range(0, 7) == 0);
      bus.br_target = rnd_tgt();
      bus.jal_taken = ($urandom_range(0, 9) == 0);
      bus.jal_target = rnd_tgt();
      tick();
      checks++;
      if (bus.PCF !== m_pc || bus.pcf_valid !== m_v
          || bus.misalign_fault !== m_flt || bus.fault_addr !== m_faddr
          || bus.redirect_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_%0d got %h %b %b %h %0d want %h %b %b %h %0d",
                 i, bus.PCF, bus.pcf_valid, bus.misalign_fault,
                 bus.fault_addr, bus.redirect_cnt,
                 m_pc, m_v, m_flt, m_faddr, m_cnt);
      end
    end
    idle_in();
  endtask

  task automatic test_wrap_saturate();
    logic [1:0] exp_cnt;
    sbus.en = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    checks++;
    if (sbus.PCF !== 8'hF8) begin
      errors++;
      $display("FAIL small_reset got %h want f8", sbus.PCF);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sbus.PCF !== 8'hFC) begin
      errors++;
      $display("FAIL small_fc got %h want fc", sbus.PCF);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sbus.PCF !== 8'h00) begin
      errors++;
      $display("FAIL wrap got %h want 00", sbus.PCF);
    end
    sbus.jal_taken = 1'b1; sbus.jal_target = 8'h10;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      checks++;
      if (sbus.redirect_cnt !== exp_cnt || sbus.PCF !== 8'h10) begin
        errors++;
        $display("FAIL sat_%0d cnt %0d pc %h want %0d pc 10",
                 i, sbus.redirect_cnt, sbus.PCF, exp_cnt);
      end
    end
    sbus.jal_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    idle_in();
    sbus.en = 1'b1;       sbus.clear = 1'b0;
    sbus.trap_req = 1'b0; sbus.trap_target = '0;
    sbus.jalr_taken = 1'b0; sbus.jalr_target = '0;
    sbus.br_taken = 1'b0; sbus.br_target = '0;
    sbus.jal_taken = 1'b0; sbus.jal_target = '0;
    #2;
    test_reset();
    test_priority();
    test_stall_redirect();
    test_misalign();
    test_clear();
    test_back_to_back();
    test_random();
    test_wrap_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
